// File: rtl/watch_pkg.sv
// Shared types and BCD limits for the digital watch alarm logic.
package watch_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD
  } alarm_state_t;

  localparam bcd_digit_t MAX_MS_HR      = 4'd2;
  localparam bcd_digit_t MAX_LS_HR_AT_2 = 4'd3;
  localparam bcd_digit_t MAX_MS_MIN     = 4'd5;
  localparam bcd_digit_t MAX_DIGIT      = 4'd9;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Keypad, time and alarm-register signals of the alarm controller.
interface alarm_ctrl_if;
  import watch_pkg::*;

  bcd_digit_t key;
  logic       key_valid;
  logic       alarm_button;
  logic       alarm_enable;
  logic       stop_alarm;
  logic       one_second;
  bcd_digit_t current_ms_hr, current_ls_hr, current_ms_min, current_ls_min;
  bcd_digit_t alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
  bcd_digit_t new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
  logic       load_new_alarm;
  logic       show_new_alarm;
  logic       entry_error;
  logic       sound_alarm;

  modport slave (
    input  key, key_valid, alarm_button, alarm_enable, stop_alarm, one_second,
    input  current_ms_hr, current_ls_hr, current_ms_min, current_ls_min,
    input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output load_new_alarm, show_new_alarm, entry_error, sound_alarm
  );

  modport master (
    output key, key_valid, alarm_button, alarm_enable, stop_alarm, one_second,
    output current_ms_hr, current_ls_hr, current_ms_min, current_ls_min,
    output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  load_new_alarm, show_new_alarm, entry_error, sound_alarm
  );

endinterface

// File: rtl/alarm_entry_buf.sv
// Four-digit keypad shift buffer with saturating digit count and 24-hour validity check.
module alarm_entry_buf
  import watch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       shift_i,
  input  bcd_digit_t key_i,
  output bcd_digit_t ms_hr_o,
  output bcd_digit_t ls_hr_o,
  output bcd_digit_t ms_min_o,
  output bcd_digit_t ls_min_o,
  output logic       full_o,
  output logic       valid_o
);

  bcd_digit_t ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  bcd_digit_t ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    count_d  = count_q;
    if (clear_i) begin
      ms_hr_d  = '0;
      ls_hr_d  = '0;
      ms_min_d = '0;
      ls_min_d = '0;
      count_d  = '0;
    end else if (shift_i) begin
      ms_hr_d  = ls_hr_q;
      ls_hr_d  = ms_min_q;
      ms_min_d = ls_min_q;
      ls_min_d = key_i;
      if (count_q != 3'd4) count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ms_hr_q  <= '0;
      ls_hr_q  <= '0;
      ms_min_q <= '0;
      ls_min_q <= '0;
      count_q  <= '0;
    end else begin
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
      count_q  <= count_d;
    end
  end

  // The units-of-hour limit depends on the tens digit (20-23 vs 00-19).
  always_comb begin
    valid_o = (ms_hr_q <= MAX_MS_HR) && (ms_min_q <= MAX_MS_MIN) && (ls_min_q <= MAX_DIGIT);
    if (ms_hr_q == MAX_MS_HR) valid_o = valid_o && (ls_hr_q <= MAX_LS_HR_AT_2);
    else                      valid_o = valid_o && (ls_hr_q <= MAX_DIGIT);
  end

  assign full_o   = (count_q == 3'd4);
  assign ms_hr_o  = ms_hr_q;
  assign ls_hr_o  = ls_hr_q;
  assign ms_min_o = ms_min_q;
  assign ls_min_o = ls_min_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-setting sequencer and ringing control for the digital watch.
module alarm_ctrl
  import watch_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10,
  parameter int RING_SEC    = 60
)(
  input  logic         clock,
  input  logic         reset,
  alarm_ctrl_if.slave  alarm_if
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_SEC);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC);

  alarm_state_t  state_q, state_d;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic          err_q, err_d;
  logic          buf_clear, buf_shift, buf_full, buf_valid;
  logic          key_ok;

  logic          match, match_d_q;
  logic          snd_q, snd_d;
  logic [RW-1:0] rc_q, rc_d, rc_inc;

  alarm_entry_buf u_entry_buf (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (buf_clear),
    .shift_i  (buf_shift),
    .key_i    (alarm_if.key),
    .ms_hr_o  (alarm_if.new_alarm_ms_hr),
    .ls_hr_o  (alarm_if.new_alarm_ls_hr),
    .ms_min_o (alarm_if.new_alarm_ms_min),
    .ls_min_o (alarm_if.new_alarm_ls_min),
    .full_o   (buf_full),
    .valid_o  (buf_valid)
  );

  assign key_ok = alarm_if.key_valid && (alarm_if.key <= MAX_DIGIT);
  assign to_inc = to_q + TW'(1);

  // The button outranks a same-cycle key, so a commit sees the pre-shift buffer.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    err_d     = 1'b0;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (alarm_if.alarm_button) begin
          state_d   = ENTRY;
          buf_clear = 1'b1;
          to_d      = '0;
        end
      end
      ENTRY: begin
        if (alarm_if.alarm_button) begin
          if (buf_full && buf_valid) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (key_ok) begin
          buf_shift = 1'b1;
          to_d      = '0;
        end else if (alarm_if.one_second) begin
          if (to_inc == TO_LAST) begin
            state_d = IDLE;
            to_d    = '0;
          end else begin
            to_d = to_inc;
          end
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign match = (alarm_if.current_ms_hr  == alarm_if.alarm_time_ms_hr)  &&
                 (alarm_if.current_ls_hr  == alarm_if.alarm_time_ls_hr)  &&
                 (alarm_if.current_ms_min == alarm_if.alarm_time_ms_min) &&
                 (alarm_if.current_ls_min == alarm_if.alarm_time_ls_min);
  assign rc_inc = rc_q + RW'(1);

  // Stop and disable outrank a start; a start only fires on the rising edge of match.
  always_comb begin
    snd_d = snd_q;
    rc_d  = rc_q;
    if (alarm_if.stop_alarm || !alarm_if.alarm_enable) begin
      snd_d = 1'b0;
    end else if (match && !match_d_q) begin
      snd_d = 1'b1;
      rc_d  = '0;
    end else if (snd_q && alarm_if.one_second) begin
      if (rc_inc == RING_LAST) begin
        snd_d = 1'b0;
        rc_d  = '0;
      end else begin
        rc_d = rc_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_d_q <= 1'b1;
      snd_q     <= 1'b0;
      rc_q      <= '0;
    end else begin
      match_d_q <= match;
      snd_q     <= snd_d;
      rc_q      <= rc_d;
    end
  end

  assign alarm_if.load_new_alarm = (state_q == LOAD);
  assign alarm_if.show_new_alarm = (state_q != IDLE);
  assign alarm_if.entry_error    = err_q;
  assign alarm_if.sound_alarm    = snd_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed vector bench for alarm_ctrl: entry sequencing, timeout, ringing and reset.
module tb_alarm_ctrl;
  import watch_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alarm_ctrl_if bus();

  alarm_ctrl #(.TIMEOUT_SEC(10), .RING_SEC(60)) dut (
    .clock    (clock),
    .reset    (reset),
    .alarm_if (bus)
  );

  typedef struct {
    logic        btn, kv;
    logic [3:0]  key;
    logic        sec, stop, en;
    logic [15:0] cur, alm;
    logic        load, show, err, snd;
    logic [15:0] nbuf;
  } vec_t;

  localparam logic [15:0] C  = 16'h0000;
  localparam logic [15:0] A  = 16'h9999;
  localparam logic [15:0] AT = 16'h0630;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic btn, logic kv, logic [3:0] key, logic sec, logic stop,
                              logic en, logic [15:0] cur, logic [15:0] alm, logic load,
                              logic show, logic err, logic snd, logic [15:0] nbuf);
    vec_t v;
    v.btn = btn; v.kv = kv; v.key = key; v.sec = sec; v.stop = stop; v.en = en;
    v.cur = cur; v.alm = alm; v.load = load; v.show = show; v.err = err; v.snd = snd;
    v.nbuf = nbuf;
    return v;
  endfunction

  function automatic vec_t ek(logic btn, logic kv, logic [3:0] key, logic load, logic show,
                              logic err, logic [15:0] nbuf);
    return mk(btn, kv, key, 1'b0, 1'b0, 1'b0, C, A, load, show, err, 1'b0, nbuf);
  endfunction

  function automatic vec_t rk(logic sec, logic stop, logic en, logic [15:0] cur, logic snd,
                              logic [15:0] nbuf);
    return mk(1'b0, 1'b0, 4'd0, sec, stop, en, cur, AT, 1'b0, 1'b0, 1'b0, snd, nbuf);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic load, input logic show,
                           input logic err, input logic snd, input logic [15:0] nbuf);
    chk({tag, ".load"},  {15'd0, bus.load_new_alarm}, {15'd0, load});
    chk({tag, ".show"},  {15'd0, bus.show_new_alarm}, {15'd0, show});
    chk({tag, ".err"},   {15'd0, bus.entry_error},    {15'd0, err});
    chk({tag, ".sound"}, {15'd0, bus.sound_alarm},    {15'd0, snd});
    chk({tag, ".buf"}, {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                        bus.new_alarm_ms_min, bus.new_alarm_ls_min}, nbuf);
  endtask

  task automatic set_inputs(input vec_t v);
    bus.alarm_button = v.btn;
    bus.key_valid    = v.kv;
    bus.key          = v.key;
    bus.one_second   = v.sec;
    bus.stop_alarm   = v.stop;
    bus.alarm_enable = v.en;
    {bus.current_ms_hr, bus.current_ls_hr, bus.current_ms_min, bus.current_ls_min} = v.cur;
    {bus.alarm_time_ms_hr, bus.alarm_time_ls_hr,
     bus.alarm_time_ms_min, bus.alarm_time_ls_min} = v.alm;
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clock);
    set_inputs(v);
    @(posedge clock);
    #1;
    check_out(tag, v.load, v.show, v.err, v.snd, v.nbuf);
  endtask

  initial begin
    // Entry table: commit 07:30, reject 24:00 and 12:60, accept 23:59,
    // overflow + illegal key, short entry, button beating a key.
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,7,  0,1,0,16'h0007));
    tbl.push_back(ek(0,1,3,  0,1,0,16'h0073));
    tbl.push_back(ek(0,1,0,  0,1,0,16'h0730));
    tbl.push_back(ek(1,0,0,  1,1,0,16'h0730));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h0730));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h0002));
    tbl.push_back(ek(0,1,4,  0,1,0,16'h0024));
    tbl.push_back(ek(0,1,0,  0,1,0,16'h0240));
    tbl.push_back(ek(0,1,0,  0,1,0,16'h2400));
    tbl.push_back(ek(1,0,0,  0,0,1,16'h2400));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h2400));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,1,  0,1,0,16'h0001));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h0012));
    tbl.push_back(ek(0,1,6,  0,1,0,16'h0126));
    tbl.push_back(ek(0,1,0,  0,1,0,16'h1260));
    tbl.push_back(ek(1,0,0,  0,0,1,16'h1260));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h1260));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h0002));
    tbl.push_back(ek(0,1,3,  0,1,0,16'h0023));
    tbl.push_back(ek(0,1,5,  0,1,0,16'h0235));
    tbl.push_back(ek(0,1,9,  0,1,0,16'h2359));
    tbl.push_back(ek(1,0,0,  1,1,0,16'h2359));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h2359));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,1,  0,1,0,16'h0001));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h0012));
    tbl.push_back(ek(0,1,1,  0,1,0,16'h0121));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h1212));
    tbl.push_back(ek(0,1,3,  0,1,0,16'h2123));
    tbl.push_back(ek(0,1,12, 0,1,0,16'h2123));
    tbl.push_back(ek(1,0,0,  1,1,0,16'h2123));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h2123));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,1,  0,1,0,16'h0001));
    tbl.push_back(ek(1,0,0,  0,0,1,16'h0001));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h0001));
    tbl.push_back(ek(1,0,0,  0,1,0,16'h0000));
    tbl.push_back(ek(0,1,1,  0,1,0,16'h0001));
    tbl.push_back(ek(0,1,2,  0,1,0,16'h0012));
    tbl.push_back(ek(0,1,3,  0,1,0,16'h0123));
    tbl.push_back(ek(0,1,4,  0,1,0,16'h1234));
    tbl.push_back(ek(1,1,5,  1,1,0,16'h1234));
    tbl.push_back(ek(0,0,0,  0,0,0,16'h1234));

    set_inputs(ek(0,0,0, 0,0,0,16'h0000));
    #12;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Entry timeout after 10 idle ticks.
    run(ek(1,0,0, 0,1,0,16'h0000), "to.btn");
    run(ek(0,1,1, 0,1,0,16'h0001), "to.k1");
    run(ek(0,1,2, 0,1,0,16'h0012), "to.k2");
    for (int k = 1; k <= 9; k++)
      run(mk(0,0,0,1,0,0,C,A, 0,1,0,0,16'h0012), $sformatf("to.tick%0d", k));
    run(mk(0,0,0,1,0,0,C,A, 0,0,0,0,16'h0012), "to.tick10");
    run(ek(0,0,0, 0,0,0,16'h0012), "to.after");

    // A legal key after tick 9 restarts the timeout.
    run(ek(1,0,0, 0,1,0,16'h0000), "tr.btn");
    run(ek(0,1,1, 0,1,0,16'h0001), "tr.k1");
    for (int k = 1; k <= 9; k++)
      run(mk(0,0,0,1,0,0,C,A, 0,1,0,0,16'h0001), $sformatf("tr.a%0d", k));
    run(ek(0,1,5, 0,1,0,16'h0015), "tr.k5");
    for (int k = 1; k <= 9; k++)
      run(mk(0,0,0,1,0,0,C,A, 0,1,0,0,16'h0015), $sformatf("tr.b%0d", k));
    run(mk(0,0,0,1,0,0,C,A, 0,0,0,0,16'h0015), "tr.b10");

    // An illegal key does not restart the timeout.
    run(ek(1,0,0, 0,1,0,16'h0000), "ti.btn");
    for (int k = 1; k <= 5; k++)
      run(mk(0,0,0,1,0,0,C,A, 0,1,0,0,16'h0000), $sformatf("ti.a%0d", k));
    run(ek(0,1,12, 0,1,0,16'h0000), "ti.k12");
    for (int k = 6; k <= 9; k++)
      run(mk(0,0,0,1,0,0,C,A, 0,1,0,0,16'h0000), $sformatf("ti.a%0d", k));
    run(mk(0,0,0,1,0,0,C,A, 0,0,0,0,16'h0000), "ti.a10");

    // Times already equal when reset releases: no ring.
    @(negedge clock);
    set_inputs(rk(0,0,1,AT,0,16'h0000));
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) run(rk(0,0,1,AT,0,16'h0000), $sformatf("eq%0d", k));

    // Ring on 06:29 -> 06:30, timing out after 60 ticks.
    run(rk(0,0,1,16'h0629,0,16'h0000), "r1.pre");
    run(rk(0,0,1,AT,1,16'h0000), "r1.rise");
    for (int k = 1; k <= 59; k++) run(rk(1,0,1,AT,1,16'h0000), $sformatf("r1.t%0d", k));
    run(rk(1,0,1,AT,0,16'h0000), "r1.t60");
    run(rk(0,0,1,AT,0,16'h0000), "r1.hold");

    // Stop after 5 ticks.
    run(rk(0,0,1,16'h0629,0,16'h0000), "r2.pre");
    run(rk(0,0,1,AT,1,16'h0000), "r2.rise");
    for (int k = 1; k <= 5; k++) run(rk(1,0,1,AT,1,16'h0000), $sformatf("r2.t%0d", k));
    run(rk(0,1,1,AT,0,16'h0000), "r2.stop");
    run(rk(0,0,1,AT,0,16'h0000), "r2.hold");

    // Stop coinciding with the match edge wins.
    run(rk(0,0,1,16'h0629,0,16'h0000), "r3.pre");
    run(rk(0,1,1,AT,0,16'h0000), "r3.stopedge");
    run(rk(0,0,1,AT,0,16'h0000), "r3.hold");

    // Dropping alarm_enable silences the alarm.
    run(rk(0,0,1,16'h0629,0,16'h0000), "r4.pre");
    run(rk(0,0,1,AT,1,16'h0000), "r4.rise");
    run(rk(0,0,0,AT,0,16'h0000), "r4.disable");

    // Ringing survives an entry and commit.
    run(rk(0,0,1,16'h0629,0,16'h0000), "r5.pre");
    run(rk(0,0,1,AT,1,16'h0000), "r5.rise");
    run(mk(1,0,0,0,0,1,AT,AT, 0,1,0,1,16'h0000), "r5.btn");
    run(mk(0,1,0,0,0,1,AT,AT, 0,1,0,1,16'h0000), "r5.k0");
    run(mk(0,1,7,0,0,1,AT,AT, 0,1,0,1,16'h0007), "r5.k7");
    run(mk(0,1,0,0,0,1,AT,AT, 0,1,0,1,16'h0070), "r5.k0b");
    run(mk(0,1,0,0,0,1,AT,AT, 0,1,0,1,16'h0700), "r5.k0c");
    run(mk(1,0,0,0,0,1,AT,AT, 1,1,0,1,16'h0700), "r5.commit");
    run(mk(0,0,0,0,0,1,AT,AT, 0,0,0,1,16'h0700), "r5.after");

    // Reset mid-entry while ringing.
    run(mk(1,0,0,0,0,1,AT,AT, 0,1,0,1,16'h0000), "rs.btn");
    run(mk(0,1,1,0,0,1,AT,AT, 0,1,0,1,16'h0001), "rs.k1");
    run(mk(0,1,2,0,0,1,AT,AT, 0,1,0,1,16'h0012), "rs.k2");
    @(negedge clock);
    set_inputs(mk(0,0,0,0,0,1,AT,AT, 0,0,0,0,16'h0000));
    #2;
    reset = 1'b1;
    #1;
    check_out("rs.async", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    run(mk(0,0,0,0,0,1,AT,AT, 0,0,0,0,16'h0000), "rs.after");
    run(mk(1,0,0,0,0,1,AT,AT, 0,1,0,0,16'h0000), "rs.btn2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

endmodule
